debounce_toggle_pulse: RTL and testbench

- Upstream conditioning stage for the T flip-flop. Takes a raw, bouncing, asynchronous push-button input and produces two signals:
  - a clean debounced level;
  - a single-cycle rising-edge pulse, wired directly to the flip-flop's T input so that each press toggles Q exactly once.
- Contains a 2-flop synchronizer, a stability counter and a 4-state FSM.

---
 rtl/debounce_toggle_pulse_if.sv | 9 +
 rtl/debounce_toggle_pulse.sv | 94 +++++++++
 tb/tb_debounce_toggle_pulse.sv | 134 +++++++++++++
 3 files changed

// File: rtl/debounce_toggle_pulse_if.sv
// debounce_toggle_pulse_if: button/debounce signals (btn_in raw press; level, pulse, busy conditioned outputs)
interface debounce_toggle_pulse_if;
  logic btn_in;
  logic level;
  logic pulse;
  logic busy;
  modport master (output btn_in, input level, pulse, busy);
  modport slave (input btn_in, output level, pulse, busy);
endinterface

// File: rtl/debounce_toggle_pulse.sv
// debounce_toggle_pulse: sync+debounce btn_in into level and one-cycle press pulse, busy while timing (clk, rst, bus.slave; DEBOUNCE_REPEAT_EN adds auto-repeat)
module debounce_toggle_pulse #(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W = $clog2(STABLE_CYCLES + 1),
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input logic clk,
  input logic rst,
  debounce_toggle_pulse_if.slave bus
);
  typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  state_t state_q, state_d;
  logic s1_q, s2_q, level_q, level_d, pulse_q, pulse_d, busy_q, busy_d, acc_pulse;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  if (STABLE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      state_q <= LOW;
      cnt_q <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      s1_q <= bus.btn_in;
      s2_q <= s1_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      busy_q <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    level_d = level_q;
    acc_pulse = 1'b0;
    case (state_q)
      LOW: if (s2_q) begin
        state_d = WAIT_HIGH;
        cnt_d = CNT_W'(1);
      end
      WAIT_HIGH: if (!s2_q) state_d = LOW;
      else if (cnt_q == LAST) begin
        state_d = HIGH;
        level_d = 1'b1;
        acc_pulse = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      HIGH: if (!s2_q) begin
        state_d = WAIT_LOW;
        cnt_d = CNT_W'(1);
      end
      WAIT_LOW: if (s2_q) state_d = HIGH;
      else if (cnt_q == LAST) begin
        state_d = LOW;
        level_d = 1'b0;
      end else cnt_d = cnt_q + 1'b1;
    endcase
    busy_d = state_d inside {WAIT_HIGH, WAIT_LOW};
  end
`ifdef DEBOUNCE_REPEAT_EN
  localparam int REP_MAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W = $clog2(REP_MAX + 1);
  logic [REP_W-1:0] rep_q, rep_d, rep_lim;
  logic rep_on_q, rep_on_d, rep_hit, stay;
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q <= '0;
      rep_on_q <= 1'b0;
    end else begin
      rep_q <= rep_d;
      rep_on_q <= rep_on_d;
    end
  end
  always_comb begin
    stay = state_q == HIGH && state_d == HIGH;
    rep_lim = rep_on_q ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY);
    rep_hit = stay && rep_q + 1'b1 == rep_lim;
    rep_d = stay && !rep_hit ? rep_q + 1'b1 : '0;
    rep_on_d = stay && (rep_on_q || rep_hit);
  end
  assign pulse_d = acc_pulse | rep_hit;
`else
  assign pulse_d = acc_pulse;
`endif
  assign bus.level = level_q;
  assign bus.pulse = pulse_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_debounce_toggle_pulse.sv
// tb_debounce_toggle_pulse: randomized and directed checks of debounce_toggle_pulse against an acceptance-rule model
module tb_debounce_toggle_pulse;
  localparam int SC = 4, RD = 8, RP = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0, checks = 0, pulses = 0;
  bit pipe[$];
  bit m_level, m_pulse, m_busy, m_high;
  int run, hold;
  always #5 clk = ~clk;
  debounce_toggle_pulse_if bus ();
  debounce_toggle_pulse #(.STABLE_CYCLES(SC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_edge(input bit r, input bit b);
    bit seen, was_high;
    if (r) begin
      pipe = '{1'b0, 1'b0};
      m_level = 0;
      m_pulse = 0;
      m_high = 0;
      run = 0;
      hold = 0;
    end else begin
      seen = pipe[0];
      void'(pipe.pop_front());
      pipe.push_back(b);
      was_high = m_high;
      m_pulse = 0;
      if (seen != m_level) begin
        run++;
        if (run == SC) begin
          m_level = seen;
          m_pulse = seen;
          run = 0;
        end
      end else run = 0;
      m_high = m_level && run == 0;
      hold = (was_high && m_high) ? hold + 1 : 0;
`ifdef DEBOUNCE_REPEAT_EN
      if (was_high && m_high && hold >= RD && (hold - RD) % RP == 0) m_pulse = 1;
`endif
    end
    m_busy = run > 0;
  endtask
  task automatic cyc(input bit r, input bit b, input string tag);
    rst = r;
    bus.btn_in = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
    check({tag, ".level"}, bus.level, m_level);
    check({tag, ".pulse"}, bus.pulse, m_pulse);
    check({tag, ".busy"}, bus.busy, m_busy);
    if (bus.pulse === 1'b1) pulses++;
  endtask
  initial begin
    int p0, len;
    bit v;
    pipe = '{1'b0, 1'b0};
    bus.btn_in = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1, 1, "reset");
    check("reset_outputs", {bus.level, bus.pulse, bus.busy}, 3'b000);
    for (int i = 0; i < 6; i++) cyc(0, 1, "held_release");
    check("held_pulse6", bus.pulse, 1);
    cyc(0, 1, "held_after");
    check("held_pulse_end", bus.pulse, 0);
    check("held_level", bus.level, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, "release");
    check("release_level", bus.level, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, "clean");
    check("clean_busy3", bus.busy, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, "clean");
    check("clean_level6", {bus.level, bus.pulse}, 2'b11);
    cyc(0, 1, "clean");
    check("clean_pulse7", bus.pulse, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, "idle");
    p0 = pulses;
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1, "bounce");
      cyc(0, 1, "bounce");
      cyc(0, 0, "bounce");
      cyc(0, 0, "bounce");
    end
    check("bounce_no_pulse", pulses - p0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, "bounce_hold");
    check("bounce_pulse6", bus.pulse, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, "bounce_hold");
    p0 = pulses;
    cyc(0, 0, "glitch");
    cyc(0, 0, "glitch");
    for (int i = 0; i < 3; i++) cyc(0, 1, "glitch");
    check("glitch_level", bus.level, 1);
    for (int i = 0; i < 5; i++) cyc(0, 0, "fall");
    check("fall_level5", bus.level, 1);
    cyc(0, 0, "fall");
    check("fall_level6", bus.level, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, "fall");
    check("release_no_pulse", pulses - p0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, "midcount");
    check("midcount_busy", bus.busy, 1);
    p0 = pulses;
    cyc(1, 1, "midcount_rst");
    check("midcount_rst", {bus.level, bus.busy, bus.pulse}, 3'b000);
    for (int i = 0; i < 6; i++) cyc(0, 1, "midcount_after");
    check("midcount_pulse6", bus.pulse, 1);
    check("midcount_one", pulses - p0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, "idle");
    p0 = pulses;
    for (int i = 0; i < 30; i++) cyc(0, 1, "repeat");
    for (int i = 0; i < 10; i++) cyc(0, 0, "repeat");
`ifdef DEBOUNCE_REPEAT_EN
    check("repeat_count", pulses - p0, 5);
`else
    check("repeat_count", pulses - p0, 1);
`endif
    for (int n = 0; n < 300; n++) begin
      v = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) cyc(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, v, "random");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
